// File: rtl/master_axi_read_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : master_axi_read_arbiter                                       |
// | Purpose  : Round-robin sharing of one AXI read transactor (AR + R paths) |
// |            among REQUESTER_COUNT client engines.                         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module master_axi_read_arbiter #(
    parameter int REQUESTER_COUNT = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int WORD_WIDTH      = 32,
    parameter int AXLEN_WIDTH     = 8,
    parameter int AXBURST_WIDTH   = 2
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [REQUESTER_COUNT-1:0]               req_valid,
    input  logic [REQUESTER_COUNT*ADDR_WIDTH-1:0]    req_address,
    input  logic [REQUESTER_COUNT*AXLEN_WIDTH-1:0]   req_count,
    input  logic [REQUESTER_COUNT*AXBURST_WIDTH-1:0] req_type,
    output logic [REQUESTER_COUNT-1:0]               req_grant,
    output logic [REQUESTER_COUNT-1:0]               req_done,
    output logic                                     req_error,
    output logic [WORD_WIDTH-1:0]                    resp_data,
    output logic [REQUESTER_COUNT-1:0]               resp_valid,
    input  logic [REQUESTER_COUNT-1:0]               resp_ready,
    output logic [ADDR_WIDTH-1:0]                    ar_system_address,
    output logic [AXLEN_WIDTH-1:0]                   ar_system_count,
    output logic [AXBURST_WIDTH-1:0]                 ar_system_type,
    output logic                                     ar_system_address_wren,
    output logic                                     ar_system_count_wren,
    output logic                                     ar_system_type_wren,
    output logic                                     ar_system_start,
    input  logic                                     ar_system_ready,
    input  logic [WORD_WIDTH-1:0]                    r_system_data,
    input  logic                                     r_system_error,
    input  logic                                     r_system_valid,
    output logic                                     r_system_ready
);

    localparam int c_IDX_W = (REQUESTER_COUNT > 1) ? $clog2(REQUESTER_COUNT) : 1;
    localparam int c_SUM_W = c_IDX_W + 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_START = 2'd2;
    localparam logic [1:0] c_ST_DATA  = 2'd3;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic [c_IDX_W-1:0]         r_ptr;
    logic [c_IDX_W-1:0]         r_winner;
    logic [c_IDX_W-1:0]         w_pick;
    logic [c_IDX_W-1:0]         w_next_ptr;
    logic [c_SUM_W-1:0]         w_sum;
    logic                       w_found;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [AXLEN_WIDTH-1:0]     r_count;
    logic [AXBURST_WIDTH-1:0]   r_type;
    logic [AXLEN_WIDTH:0]       r_beat;
    logic                       r_error;
    logic [REQUESTER_COUNT-1:0] r_done;
    logic                       w_accept;
    logic                       w_granted;
    logic                       w_in_data;
    logic                       w_hs;
    logic                       w_last;

    // Scan upward from the rotating pointer; the first pending requester wins.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < REQUESTER_COUNT; k++) begin
            w_sum = {1'b0, r_ptr} + c_SUM_W'(k);
            if (w_sum >= c_SUM_W'(REQUESTER_COUNT)) begin
                w_sum = w_sum - c_SUM_W'(REQUESTER_COUNT);
            end
            if (!w_found && req_valid[w_sum[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[c_IDX_W-1:0];
            end
        end
    end

    assign w_next_ptr = (r_winner == c_IDX_W'(REQUESTER_COUNT - 1)) ? '0
                                                                     : r_winner + c_IDX_W'(1);

    assign w_accept  = (r_state == c_ST_IDLE) && w_found && ar_system_ready;
    assign w_granted = (r_state != c_ST_IDLE);
    assign w_in_data = (r_state == c_ST_DATA);
    assign w_hs      = w_in_data && r_system_valid && resp_ready[r_winner];
    // Counter is one bit wider than arlen so a 256-beat burst cannot wrap early.
    assign w_last    = w_hs && (r_beat == {1'b0, r_count});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept) w_state_nxt = c_ST_LOAD;
            c_ST_LOAD:  w_state_nxt = c_ST_START;
            c_ST_START: w_state_nxt = c_ST_DATA;
            c_ST_DATA:  if (w_last) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_winner <= '0;
            r_addr   <= '0;
            r_count  <= '0;
            r_type   <= '0;
            r_beat   <= '0;
            r_error  <= 1'b0;
            r_done   <= '0;
        end else begin
            r_done <= '0;
            if (w_accept) begin
                r_winner <= w_pick;
                r_addr   <= req_address[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
                r_count  <= req_count[w_pick*AXLEN_WIDTH +: AXLEN_WIDTH];
                r_type   <= req_type[w_pick*AXBURST_WIDTH +: AXBURST_WIDTH];
            end
            if (r_state == c_ST_START) begin
                r_beat  <= '0;
                r_error <= 1'b0;
            end
            if (w_hs) begin
                r_beat  <= r_beat + 1'b1;
                r_error <= r_error | r_system_error;
            end
            if (w_last) begin
                r_done <= req_grant;
                r_ptr  <= w_next_ptr;
            end
        end
    end

    for (genvar g = 0; g < REQUESTER_COUNT; g++) begin : g_requester
        assign req_grant[g]  = w_granted && (r_winner == c_IDX_W'(g));
        assign resp_valid[g] = w_in_data && r_system_valid && (r_winner == c_IDX_W'(g));
    end

    assign req_done               = r_done;
    assign req_error              = r_error;
    assign resp_data              = r_system_data;
    assign r_system_ready         = w_in_data && resp_ready[r_winner];
    assign ar_system_address      = r_addr;
    assign ar_system_count        = r_count;
    assign ar_system_type         = r_type;
    assign ar_system_address_wren = (r_state == c_ST_LOAD);
    assign ar_system_count_wren   = (r_state == c_ST_LOAD);
    assign ar_system_type_wren    = (r_state == c_ST_LOAD);
    assign ar_system_start        = (r_state == c_ST_START);

endmodule
`default_nettype wire

// File: tb/tb_master_axi_read_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_master_axi_read_arbiter                                    |
// | Purpose  : Randomized scoreboard bench for master_axi_read_arbiter.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_master_axi_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int BW = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_address;
    logic [N*LW-1:0] req_count;
    logic [N*BW-1:0] req_type;
    logic [N-1:0]    req_grant;
    logic [N-1:0]    req_done;
    logic            req_error;
    logic [DW-1:0]   resp_data;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [AW-1:0]   ar_system_address;
    logic [LW-1:0]   ar_system_count;
    logic [BW-1:0]   ar_system_type;
    logic            ar_system_address_wren;
    logic            ar_system_count_wren;
    logic            ar_system_type_wren;
    logic            ar_system_start;
    logic            ar_system_ready;
    logic [DW-1:0]   r_system_data;
    logic            r_system_error;
    logic            r_system_valid;
    logic            r_system_ready;

    master_axi_read_arbiter #(
        .REQUESTER_COUNT(N), .ADDR_WIDTH(AW), .WORD_WIDTH(DW),
        .AXLEN_WIDTH(LW), .AXBURST_WIDTH(BW)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_address(req_address), .req_count(req_count),
        .req_type(req_type), .req_grant(req_grant), .req_done(req_done),
        .req_error(req_error), .resp_data(resp_data), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .ar_system_address(ar_system_address),
        .ar_system_count(ar_system_count), .ar_system_type(ar_system_type),
        .ar_system_address_wren(ar_system_address_wren),
        .ar_system_count_wren(ar_system_count_wren),
        .ar_system_type_wren(ar_system_type_wren),
        .ar_system_start(ar_system_start), .ar_system_ready(ar_system_ready),
        .r_system_data(r_system_data), .r_system_error(r_system_error),
        .r_system_valid(r_system_valid), .r_system_ready(r_system_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          w;
        logic [AW-1:0] addr;
        logic [LW-1:0] cnt;
        logic [BW-1:0] typ;
        int          cyc;
    } grant_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } beat_t;

    grant_t exp_q[$];
    beat_t  beat_q[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_bursts = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // Requester-side state and transactor model
    logic [N-1:0]  pend;
    logic [N-1:0]  first;
    logic [AW-1:0] ra [N];
    logic [LW-1:0] rc [N];
    logic [BW-1:0] rt [N];

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]              = pend[i];
            req_address[i*AW +: AW]   = ra[i];
            req_count[i*LW +: LW]     = rc[i];
            req_type[i*BW +: BW]      = rt[i];
        end
    endtask

    // Monitor: checks DUT outputs against expectations popped from the queues
    int   cur_w = 0;
    int   cur_cnt = 0;
    int   beats = 0;
    logic cur_err = 1'b0;
    logic busy = 1'b0;
    logic in_data = 1'b0;
    logic done_pend = 1'b0;
    logic load_prev = 1'b0;

    always @(negedge clock) begin
        grant_t g;
        beat_t  b;
        logic   last;
        if (mon_en) begin
            last = 1'b0;
            if (done_pend) begin
                chk("req_done", req_done, onehot(cur_w));
                chk("req_error", req_error, cur_err);
                done_pend = 1'b0;
                n_bursts++;
            end else begin
                chk("req_done_quiet", req_done, 0);
            end

            chk("start_after_load", ar_system_start, load_prev);
            if (ar_system_address_wren) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_load", 1, 0);
                end else begin
                    g = exp_q.pop_front();
                    cur_w = g.w; cur_cnt = int'(g.cnt); beats = 0; cur_err = 1'b0; busy = 1'b1;
                    chk("ar_address", ar_system_address, g.addr);
                    chk("ar_count", ar_system_count, g.cnt);
                    chk("ar_type", ar_system_type, g.typ);
                    chk("ar_wren_all", {ar_system_count_wren, ar_system_type_wren}, 2'b11);
                end
            end else begin
                chk("ar_wren_quiet", {ar_system_count_wren, ar_system_type_wren}, 0);
                if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    chk("load_missing", 0, 1);
                    void'(exp_q.pop_front());
                end
            end
            load_prev = ar_system_address_wren;

            if (in_data) begin
                chk("resp_valid", resp_valid, r_system_valid ? onehot(cur_w) : '0);
                chk("r_system_ready", r_system_ready, resp_ready[cur_w]);
                if (r_system_valid && resp_ready[cur_w]) begin
                    if (beat_q.size() == 0) begin
                        chk("beat_underflow", 1, 0);
                    end else begin
                        b = beat_q.pop_front();
                        chk("resp_data", resp_data, b.data);
                        cur_err = cur_err | b.err;
                        beats++;
                        if (beats == cur_cnt + 1) begin
                            last = 1'b1;
                            done_pend = 1'b1;
                        end
                    end
                end
            end else begin
                chk("resp_valid_quiet", resp_valid, 0);
                chk("r_ready_quiet", r_system_ready, 0);
            end

            chk("req_grant", req_grant, busy ? onehot(cur_w) : '0);
            if (last) begin
                busy = 1'b0;
                in_data = 1'b0;
            end
            if (ar_system_start) in_data = 1'b1;
        end
    end

    initial begin
        logic          hs;
        logic          gen_en;
        logic          t_active;
        logic          t_have;
        int            t_left;
        logic [DW-1:0] t_data;
        logic          t_err;
        logic          m_active;
        int            m_ptr;
        int            m_w;
        logic          found;
        grant_t        g;
        beat_t         b;

        pend = '0; first = '1; gen_en = 1'b1;
        t_active = 1'b0; t_have = 1'b0; t_left = 0; t_data = '0; t_err = 1'b0;
        m_active = 1'b0; m_ptr = 0; m_w = 0; hs = 1'b0;
        for (int i = 0; i < N; i++) begin
            ra[i] = 32'h1000 + i; rc[i] = 8'd3; rt[i] = 2'd1;
        end
        req_valid = '0; req_address = '0; req_count = '0; req_type = '0;
        drive_reqs();
        req_valid = '1;
        resp_ready = '1; ar_system_ready = 1'b1;
        r_system_data = 32'hDEADBEEF; r_system_error = 1'b1; r_system_valid = 1'b1;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_grant", req_grant, 0);
        chk("rst_done", req_done, 0);
        chk("rst_error", req_error, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_r_ready", r_system_ready, 0);
        chk("rst_ar_address", ar_system_address, 0);
        chk("rst_ar_count_type", {ar_system_count, ar_system_type}, 0);
        chk("rst_wren_start", {ar_system_address_wren, ar_system_count_wren,
                               ar_system_type_wren, ar_system_start}, 0);
        chk("rst_resp_data", resp_data, 32'hDEADBEEF);

        r_system_valid = 1'b0;
        drive_reqs();
        @(posedge clock); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        for (int cy = 0; cy < 9000; cy++) begin
            if (cy >= 3000) gen_en = 1'b0;
            if (!gen_en && pend == '0 && !m_active && !t_active) break;
            @(negedge clock);
            hs = r_system_valid & r_system_ready;
            @(posedge clock); #1;
            cyc++;
            for (int i = 0; i < N; i++) if (req_done[i]) pend[i] = 1'b0;

            // transactor side: count+1 beats per start, gaps before each beat
            if (hs && t_have) begin
                t_have = 1'b0;
                t_left--;
                if (t_left == 0) begin
                    t_active = 1'b0;
                    m_active = 1'b0;
                    m_ptr = (m_w + 1) % N;
                end
            end
            if (ar_system_start) begin
                t_active = 1'b1;
                t_left = int'(ar_system_count) + 1;
            end
            if (t_active && !t_have && ($urandom % 4 != 0)) begin
                t_data = $urandom;
                t_err = ($urandom % 8 == 0);
                b.data = t_data; b.err = t_err;
                beat_q.push_back(b);
                t_have = 1'b1;
            end
            r_system_valid = t_have;
            r_system_data  = t_have ? t_data : DW'($urandom);
            r_system_error = t_have ? t_err : 1'($urandom);
            for (int i = 0; i < N; i++) resp_ready[i] = ($urandom % 4 != 0);
            ar_system_ready = ($urandom % 8 != 0);

            if (gen_en) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i] && ($urandom % 4 == 0)) begin
                        ra[i] = $urandom;
                        rc[i] = ($urandom % 32 == 0) ? 8'd255 : 8'($urandom % 8);
                        rt[i] = 2'($urandom);
                        if (first[i]) begin
                            if (i == 0) begin ra[i] = 32'h100; rc[i] = 8'd3; rt[i] = 2'd1; end
                            if (i == 3) rc[i] = 8'd255;
                            first[i] = 1'b0;
                        end
                        pend[i] = 1'b1;
                    end
                end
            end
            drive_reqs();

            // reference arbitration: first pending requester at or after the pointer
            if (!m_active && (req_valid != '0) && ar_system_ready) begin
                for (int k = 0; k < N; k++) begin
                    if (req_valid[(m_ptr + k) % N]) begin
                        m_w = (m_ptr + k) % N;
                        break;
                    end
                end
                g.w = m_w; g.addr = ra[m_w]; g.cnt = rc[m_w]; g.typ = rt[m_w]; g.cyc = cyc;
                exp_q.push_back(g);
                m_active = 1'b1;
            end
        end
        repeat (2) @(posedge clock);
        #1;
        mon_en = 1'b0;
        chk("drained", {pend, m_active, t_active}, 0);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("beat_q_empty", beat_q.size(), 0);
        chk("bursts_completed", n_bursts > 20, 1);

        // Held-off address channel: no grant, no strobes
        for (int i = 0; i < N; i++) pend[i] = 1'b1;
        drive_reqs();
        ar_system_ready = 1'b0;
        r_system_valid = 1'b0;
        repeat (8) begin
            @(posedge clock); #1;
            chk("arready_low_grant", req_grant, 0);
            chk("arready_low_wren", ar_system_address_wren, 0);
        end

        // Reset during the first DATA beat
        pend = 4'b0100;
        for (int i = 0; i < N; i++) rc[i] = 8'd3;
        drive_reqs();
        ar_system_ready = 1'b1;
        resp_ready = '1;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            if (ar_system_start) begin found = 1'b1; break; end
        end
        chk("rst_test_start_seen", found, 1);
        r_system_valid = 1'b1;
        r_system_data  = 32'hA5A5_5A5A;
        @(posedge clock); #1;
        chk("rst_test_in_data", resp_valid, 4'b0100);
        reset = 1'b1;
        #1;
        chk("midrst_grant", req_grant, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_r_ready", r_system_ready, 0);
        chk("midrst_ar_fields", {ar_system_address, ar_system_count, ar_system_type}, 0);
        chk("midrst_strobes", {ar_system_address_wren, ar_system_start, req_done, req_error}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        r_system_valid = 1'b0;
        pend = '1;
        drive_reqs();
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            if (ar_system_address_wren) begin found = 1'b1; break; end
        end
        chk("post_rst_load_seen", found, 1);
        chk("post_rst_ptr_zero", req_grant, 4'b0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/master_axi_read_arbiter.md
# master_axi_read_arbiter

Round-robin arbiter sharing one Master AXI Transactor read path (AR system interface plus R system interface) among REQUESTER_COUNT requesters. Accepts a burst request from one requester, programs address/count/type into the transactor, issues the start pulse, then steers the returned read-data beats to that requester until the burst completes. Priority then rotates to the next requester. Sits between client engines and the transactor's `ar_system_*` and `r_system_*` ports.

## Interface
- REQUESTER_COUNT, 4, number of requesters (2..16)
- ADDR_WIDTH, 0, byte address width; must match the transactor
- WORD_WIDTH, 0, read data width; must match the transactor
- AXLEN_WIDTH, 8, burst count width (AXI4 fixed)
- AXBURST_WIDTH, 2, burst type width (AXI4 fixed)

Ports:
- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  REQUESTER_COUNT  request pending, one bit per requester
- req_address  in  REQUESTER_COUNT*ADDR_WIDTH  packed; requester i occupies slice i
- req_count  in  REQUESTER_COUNT*AXLEN_WIDTH  packed arlen; beats = count+1
- req_type  in  REQUESTER_COUNT*AXBURST_WIDTH  packed burst type
- req_grant  out  REQUESTER_COUNT  one-hot; held from LOAD through DATA
- req_done  out  REQUESTER_COUNT  one-cycle pulse to the winner after its last beat
- req_error  out  1  sticky OR of r_system_error over the burst; valid while req_done is high
- resp_data  out  WORD_WIDTH  r_system_data, broadcast to all requesters
- resp_valid  out  REQUESTER_COUNT  r_system_valid gated to the winner only
- resp_ready  in  REQUESTER_COUNT  per-requester data ready
- ar_system_address / _count / _type  out  ADDR_WIDTH / AXLEN_WIDTH / AXBURST_WIDTH  winner's fields, registered
- ar_system_address_wren, ar_system_count_wren, ar_system_type_wren  out  1  write strobes
- ar_system_start  out  1  start pulse
- ar_system_ready  in  1  transactor address channel idle
- r_system_data  in  WORD_WIDTH
- r_system_error  in  1
- r_system_valid  in  1
- r_system_ready  out  1

## Operation
- State machine: IDLE, LOAD, START, DATA.
- **IDLE**
  - When any req_valid bit is high and ar_system_ready is high, select the winner as the first set bit scanning upward from pointer `ptr`, wrapping at REQUESTER_COUNT.
  - Register the winner index and its address/count/type slices, then go to LOAD.
  - If ar_system_ready is low, stay in IDLE and grant nothing.
- **LOAD** (1 cycle)
  - All three wren high; ar_system_* fields carry the winner's registered values.
  - req_grant for the winner is set.
  - Go to START.
- **START** (1 cycle): ar_system_start high. Clear the beat counter and the error flag, then go to DATA.
- **DATA**
  - Pass-through:
    - resp_valid[w] = r_system_valid
    - r_system_ready = resp_ready[w]
    - all other resp_valid bits are 0
  - On each r_system_valid & r_system_ready:
    - increment the 9-bit beat counter
    - OR r_system_error into the error flag
  - When a handshake occurs with counter == count (count+1 beats total):
    - the next cycle pulses req_done[w] with the final req_error
    - grant drops
    - ptr becomes (w+1) mod REQUESTER_COUNT
    - state returns to IDLE
- Data handshakes are ignored outside DATA: r_system_ready = 0, resp_valid = 0.
- req_valid, req_address, req_count and req_type are sampled only in IDLE. A requester dropping req_valid mid-burst does not abort the burst.
- Count arithmetic: a 9-bit counter compared against zero-extended count. count = 255 yields 256 beats with no wrap.

## Timing
- Reset values (state IDLE, ptr 0): req_grant 0, req_done 0, req_error 0, resp_valid 0, r_system_ready 0, all ar_system_* outputs 0, resp_data = r_system_data (combinational).
- Cycle sequence:
  - request accepted in IDLE at cycle T
  - LOAD at T+1
  - START at T+2
  - first possible data beat at T+3
- Data path has zero-latency combinational handshake forwarding while in DATA.
- req_done pulses the cycle after the last beat. That same cycle is IDLE, so the next grant can begin arbitration immediately: minimum 4 cycles overhead per burst.
- Reset asserted mid-burst: outputs return to reset values immediately (asynchronous). Remaining beats are not consumed. The transactor must be reset concurrently by the system.
- Simultaneous requests: exactly one winner per arbitration, chosen by ptr. After any burst completes, the winner has lowest priority.

## Test plan
- Single requester 0, address 0x100, count 3, type 1 -> LOAD strobes carry 0x100/3/1; start 1 cycle later; 4 beats route to resp_valid[0]; req_done[0] one cycle after beat 4; req_error 0.
- All 4 requesters valid continuously, count 0 -> grant order 0,1,2,3,0 with ptr rotating; each grant lasts exactly 1 data beat.
- Requester 2 burst with resp_ready[2] toggled every cycle and r_system_valid gapped -> beat counter advances only on handshakes; other resp_valid bits stay 0.
- count 255 -> exactly 256 beats accepted before req_done; no early completion at counter wrap.
- Error on beat 2 of a 4-beat burst -> req_error = 1 with req_done; next burst reports 0.
- ar_system_ready held low with requests pending -> no grant and no wren. Reset asserted on beat 1 of DATA -> all outputs 0 immediately and ptr = 0 after release.
